// File: rtl/wave_display_reader.sv
// wave_display_reader
// Display-side reader for the oscilloscope waveform RAM. Follows a free-running
// pixel scan. For each pixel inside the 300x256 plot window it fetches the
// matching sample from the RAM and colours the pixel as trace, trigger line,
// grid or background. Output colour and delayed data-enable trail the scan
// inputs by exactly three cycles.
//
// Ports
//   clk, rstn          pixel clock; synchronous active-low reset
//   frame_start        one-cycle pulse at the start of each frame
//   pix_de/x/y         active-video enable and scan position
//   wave_hold          1 = freeze display (no capture re-arm)
//   trig_level         trigger level drawn as a horizontal line
//   ram_refresh        one-cycle capture re-arm pulse
//   wave_rd_addr/data  waveform RAM read port (data valid one cycle after addr)
//   pix_de_o, pix_rgb  delayed enable and pixel colour
module wave_display_reader #(
    parameter logic [9:0]  X0         = 10'd50,
    parameter logic [9:0]  Y0         = 10'd100,
    parameter logic [23:0] WAVE_COLOR = 24'hFFFF00,
    parameter logic [23:0] TRIG_COLOR = 24'hFF0000,
    parameter logic [23:0] GRID_COLOR = 24'h404040,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start,
    input  logic        pix_de,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        wave_hold,
    input  logic [7:0]  trig_level,
    output logic        ram_refresh,
    output logic [9:0]  wave_rd_addr,
    input  logic [7:0]  wave_rd_data,
    output logic        pix_de_o,
    output logic [23:0] pix_rgb
);

    localparam logic [10:0] XLo = {1'b0, X0};
    localparam logic [10:0] XHi = XLo + 11'd300;
    localparam logic [10:0] YLo = {1'b0, Y0};
    localparam logic [10:0] YHi = YLo + 11'd256;

    // Per-pixel flags carried alongside the RAM read.
    typedef struct packed {
        logic       de;
        logic       win;
        logic       first;  // column 0: no previous sample on this line
        logic       grid;
        logic       trig;
        logic [7:0] row;
    } stage_t;

    // ------------------------------------------------------------------
    // Stage 0: decode the incoming scan position (cycle t)
    // ------------------------------------------------------------------
    logic       x_in_cols;
    logic       y_in_rows;
    logic       in_win;
    logic [8:0] col;
    logic [7:0] row;
    logic [5:0] col_mod_q, col_mod_d;
    logic       grid_hit;
    logic       trig_hit;

    always_comb begin
        x_in_cols = (pix_x >= XLo) && (pix_x < XHi);
        y_in_rows = (pix_y >= YLo) && (pix_y < YHi);
        in_win    = pix_de && x_in_cols && y_in_rows;
        col       = 9'(pix_x - XLo);
        row       = 8'(pix_y - YLo);

        // Column modulo-50 counter: follows the scan across the window columns
        // regardless of pix_de, restarting at column 0.
        col_mod_d = col_mod_q;
        if (x_in_cols) begin
            if ((col == 9'd0) || (col_mod_q == 6'd49)) begin
                col_mod_d = 6'd0;
            end else begin
                col_mod_d = col_mod_q + 6'd1;
            end
        end

        grid_hit = (x_in_cols && (col_mod_d == 6'd0)) || (row[4:0] == 5'd0) ||
                   (col == 9'd299) || (row == 8'hFF);
        trig_hit = (row == ~trig_level);
    end

    // ------------------------------------------------------------------
    // Stage 1: register address and flags (cycle t+1)
    // ------------------------------------------------------------------
    stage_t     st1_d, st1_q;
    stage_t     st2_q;
    logic [9:0] addr_q, addr_d;
    logic       refresh_q, refresh_d;

    always_comb begin
        st1_d.de    = pix_de;
        st1_d.win   = in_win;
        st1_d.first = (col == 9'd0);
        st1_d.grid  = grid_hit;
        st1_d.trig  = trig_hit;
        st1_d.row   = row;

        addr_d    = in_win ? {1'b0, col} : addr_q;
        refresh_d = frame_start && !wave_hold;
    end

    // ------------------------------------------------------------------
    // Stage 2: RAM data valid; trace hit test (cycle t+2)
    // ------------------------------------------------------------------
    logic [7:0]  samp_row;
    logic [7:0]  prev_row;
    logic [7:0]  lo_row, hi_row;
    logic        wave_hit;
    logic [7:0]  prev_s_q, prev_s_d;
    logic [23:0] rgb_q, rgb_d;
    logic        de_o_q, de_o_d;

    always_comb begin
        // Row 255 - d is the bitwise inverse of an 8-bit sample.
        samp_row = ~wave_rd_data;
        prev_row = st2_q.first ? samp_row : prev_s_q;
        lo_row   = (samp_row < prev_row) ? samp_row : prev_row;
        hi_row   = (samp_row < prev_row) ? prev_row : samp_row;
        // Span between neighbouring samples so steep edges draw as a solid line.
        wave_hit = (st2_q.row >= lo_row) && (st2_q.row <= hi_row);

        prev_s_d = st2_q.win ? samp_row : prev_s_q;

        rgb_d = BG_COLOR;
        if (st2_q.win) begin
            if (wave_hit) begin
                rgb_d = WAVE_COLOR;
            end else if (st2_q.trig) begin
                rgb_d = TRIG_COLOR;
            end else if (st2_q.grid) begin
                rgb_d = GRID_COLOR;
            end
        end
        de_o_d = st2_q.de;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_mod_q <= '0;
            st1_q     <= '0;
            st2_q     <= '0;
            addr_q    <= '0;
            refresh_q <= 1'b0;
            prev_s_q  <= '0;
            rgb_q     <= '0;
            de_o_q    <= 1'b0;
        end else begin
            col_mod_q <= col_mod_d;
            st1_q     <= st1_d;
            st2_q     <= st1_q;
            addr_q    <= addr_d;
            refresh_q <= refresh_d;
            prev_s_q  <= prev_s_d;
            rgb_q     <= rgb_d;
            de_o_q    <= de_o_d;
        end
    end

    assign ram_refresh  = refresh_q;
    assign wave_rd_addr = addr_q;
    assign pix_de_o     = de_o_q;
    assign pix_rgb      = rgb_q;

endmodule
